// File: rtl/idex_stage_pkg.sv
// idex_stage_pkg: control-word layout and register constants shared by the ID/EX stage.
package idex_stage_pkg;
  localparam int CTRL_W = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC = 4;
  localparam int CTRL_REGDST = 3;
  localparam int CTRL_ALUOP_MSB = 2;
  localparam int CTRL_ALUOP_LSB = 0;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/idex_stage_hazard_detect.sv
// idex_hazard_detect: load-use comparator between the load in EX and the instruction in ID.
module idex_hazard_detect
  import idex_stage_pkg::*;
#(
  parameter int addr_bits = 5
) (
  input  logic                 idValid,
  input  logic                 exValid,
  input  logic                 exMemRead,
  input  logic [addr_bits-1:0] exRt,
  input  logic [addr_bits-1:0] idRs,
  input  logic [addr_bits-1:0] idRt,
  input  logic                 extStall,
  output logic                 hazardStall
);
  // A frozen EX keeps the hazard pending, so no request is raised meanwhile.
  assign hazardStall = idValid & exValid & exMemRead & ~extStall &
                       (exRt != addr_bits'(ZERO_REG)) & ((exRt == idRs) | (exRt == idRt));
endmodule

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use bubble insertion and a saturating bubble count.
// Optional IDEX_WB_BYPASS_EN adds a WB-to-operand bypass for posedge-writing register banks.
module idex_stage
  import idex_stage_pkg::*;
#(
  parameter int addr_bits = 5,
  parameter int word_wide = 32,
  parameter int cnt_bits = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [word_wide-1:0] id_readData1,
  input  logic [word_wide-1:0] id_readData2,
  input  logic [word_wide-1:0] id_imm,
  input  logic [word_wide-1:0] id_pc4,
  input  logic [addr_bits-1:0] id_rs,
  input  logic [addr_bits-1:0] id_rt,
  input  logic [addr_bits-1:0] id_rd,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 flush,
  input  logic                 ext_stall,
`ifdef IDEX_WB_BYPASS_EN
  input  logic                 wb_regWrite,
  input  logic [addr_bits-1:0] wb_writeReg,
  input  logic [word_wide-1:0] wb_writeData,
`endif
  output logic                 ex_valid,
  output logic [word_wide-1:0] ex_readData1,
  output logic [word_wide-1:0] ex_readData2,
  output logic [word_wide-1:0] ex_imm,
  output logic [word_wide-1:0] ex_pc4,
  output logic [addr_bits-1:0] ex_rs,
  output logic [addr_bits-1:0] ex_rt,
  output logic [addr_bits-1:0] ex_rd,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 hazard_stall,
  output logic [cnt_bits-1:0]  bubble_cnt
);
  logic hazardStall;
  logic loadLive;
  logic [word_wide-1:0] operand1;
  logic [word_wide-1:0] operand2;

  idex_hazard_detect #(.addr_bits(addr_bits)) hazardDetect (
    .idValid    (id_valid),
    .exValid    (ex_valid),
    .exMemRead  (ex_ctrl[CTRL_MEMREAD]),
    .exRt       (ex_rt),
    .idRs       (id_rs),
    .idRt       (id_rt),
    .extStall   (ext_stall),
    .hazardStall(hazardStall)
  );

  assign hazard_stall = hazardStall;
  assign loadLive = id_valid & ~flush & ~hazardStall;

`ifdef IDEX_WB_BYPASS_EN
  assign operand1 = (wb_regWrite && wb_writeReg != addr_bits'(ZERO_REG) && wb_writeReg == id_rs) ? wb_writeData : id_readData1;
  assign operand2 = (wb_regWrite && wb_writeReg != addr_bits'(ZERO_REG) && wb_writeReg == id_rt) ? wb_writeData : id_readData2;
`else
  assign operand1 = id_readData1;
  assign operand2 = id_readData2;
`endif

  // Data fields always follow ID; only valid/ctrl decide whether EX sees a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_readData1 <= '0;
      ex_readData2 <= '0;
      ex_imm <= '0;
      ex_pc4 <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      ex_rd <= '0;
      ex_ctrl <= '0;
      bubble_cnt <= '0;
    end else if (!ext_stall) begin
      ex_valid <= loadLive;
      ex_readData1 <= operand1;
      ex_readData2 <= operand2;
      ex_imm <= id_imm;
      ex_pc4 <= id_pc4;
      ex_rs <= id_rs;
      ex_rt <= id_rt;
      ex_rd <= id_rd;
      ex_ctrl <= loadLive ? id_ctrl : '0;
      if (!flush && hazardStall && bubble_cnt != '1) bubble_cnt <= bubble_cnt + cnt_bits'(1);
    end
  end
endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: directed checks of pass-through, load-use bubbles, priority, saturation and async reset.
module tb_idex_stage;
  localparam int AB = 5;
  localparam int WW = 32;
  localparam int CB = 4;
  logic clock = 1'b0;
  logic reset;
  logic id_valid;
  logic [WW-1:0] id_readData1, id_readData2, id_imm, id_pc4;
  logic [AB-1:0] id_rs, id_rt, id_rd;
  logic [8:0] id_ctrl;
  logic flush, ext_stall;
  logic ex_valid;
  logic [WW-1:0] ex_readData1, ex_readData2, ex_imm, ex_pc4;
  logic [AB-1:0] ex_rs, ex_rt, ex_rd;
  logic [8:0] ex_ctrl;
  logic hazard_stall;
  logic [CB-1:0] bubble_cnt;
  int errors = 0;
  int checks = 0;

  localparam logic [8:0] LW = 9'h1B0;
  localparam logic [8:0] ADD = 9'h10A;

  idex_stage #(.addr_bits(AB), .word_wide(WW), .cnt_bits(CB)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_readData1(id_readData1), .id_readData2(id_readData2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .flush(flush), .ext_stall(ext_stall),
    .ex_valid(ex_valid), .ex_readData1(ex_readData1), .ex_readData2(ex_readData2),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [AB-1:0] rs, input logic [AB-1:0] rt,
                       input logic [AB-1:0] rd, input logic [WW-1:0] pc);
    id_valid = v;
    id_ctrl = c;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    id_pc4 = pc;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    {id_valid, id_readData1, id_readData2, id_imm, id_pc4, id_rs, id_rt, id_rd, id_ctrl, flush, ext_stall} = '0;
    #3;
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_ctrl", 64'(ex_ctrl), 64'd0);
    check("rst_cnt", 64'(bubble_cnt), 64'd0);
    check("rst_hz", 64'(hazard_stall), 64'd0);
    tick();
    reset = 1'b1;
    // Pass-through; ctrl 0x1A5 carries memRead with ex_rt=2
    id_readData1 = 32'h11;
    id_readData2 = 32'h22;
    id_imm = 32'hFFFFFFFC;
    drive(1'b1, 9'h1A5, 5'd1, 5'd2, 5'd3, 32'h104);
    tick();
    check("pt_valid", 64'(ex_valid), 64'd1);
    check("pt_rd1", 64'(ex_readData1), 64'h11);
    check("pt_rd2", 64'(ex_readData2), 64'h22);
    check("pt_imm", 64'(ex_imm), 64'hFFFFFFFC);
    check("pt_pc4", 64'(ex_pc4), 64'h104);
    check("pt_ctrl", 64'(ex_ctrl), 64'h1A5);
    check("pt_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'({5'd1, 5'd2, 5'd3}));
    check("pt_hz_rt", 64'(hazard_stall), 64'd1);
    // Load-use
    drive(1'b1, LW, 5'd9, 5'd8, 5'd0, 32'h108);
    check("lw_nohz", 64'(hazard_stall), 64'd0);
    tick();
    drive(1'b1, ADD, 5'd8, 5'd9, 5'd10, 32'h10C);
    check("lu_hz", 64'(hazard_stall), 64'd1);
    tick();
    check("lu_bub_valid", 64'(ex_valid), 64'd0);
    check("lu_bub_ctrl", 64'(ex_ctrl), 64'd0);
    check("lu_cnt", 64'(bubble_cnt), 64'd1);
    check("lu_hz_clear", 64'(hazard_stall), 64'd0);
    tick();
    check("lu_add_valid", 64'(ex_valid), 64'd1);
    check("lu_add_ctrl", 64'(ex_ctrl), 64'(ADD));
    check("lu_add_rd", 64'(ex_rd), 64'd10);
    // Register $0 and non-load
    drive(1'b1, LW, 5'd3, 5'd0, 5'd0, 32'h110);
    tick();
    drive(1'b1, ADD, 5'd0, 5'd0, 5'd4, 32'h114);
    check("zero_hz", 64'(hazard_stall), 64'd0);
    drive(1'b1, ADD, 5'd1, 5'd5, 5'd6, 32'h114);
    tick();
    drive(1'b1, ADD, 5'd7, 5'd5, 5'd6, 32'h118);
    check("nonload_hz", 64'(hazard_stall), 64'd0);
    // flush together with hazard
    drive(1'b1, LW, 5'd9, 5'd8, 5'd0, 32'h11C);
    tick();
    drive(1'b1, ADD, 5'd8, 5'd1, 5'd2, 32'h120);
    flush = 1'b1;
    #1;
    check("fh_hz", 64'(hazard_stall), 64'd1);
    tick();
    check("fh_valid", 64'(ex_valid), 64'd0);
    check("fh_ctrl", 64'(ex_ctrl), 64'd0);
    check("fh_cnt", 64'(bubble_cnt), 64'd1);
    flush = 1'b0;
    // ext_stall overrides flush
    drive(1'b1, LW, 5'd9, 5'd8, 5'd0, 32'h200);
    tick();
    check("es_lw_ctrl", 64'(ex_ctrl), 64'(LW));
    drive(1'b1, ADD, 5'd8, 5'd1, 5'd2, 32'h204);
    ext_stall = 1'b1;
    flush = 1'b1;
    #1;
    check("es_hz", 64'(hazard_stall), 64'd0);
    tick();
    check("es_hold_valid", 64'(ex_valid), 64'd1);
    check("es_hold_ctrl", 64'(ex_ctrl), 64'(LW));
    check("es_hold_pc4", 64'(ex_pc4), 64'h200);
    check("es_hold_cnt", 64'(bubble_cnt), 64'd1);
    ext_stall = 1'b0;
    tick();
    check("es_rel_valid", 64'(ex_valid), 64'd0);
    check("es_rel_ctrl", 64'(ex_ctrl), 64'd0);
    check("es_rel_cnt", 64'(bubble_cnt), 64'd1);
    flush = 1'b0;
    // 17 more load-use pairs saturate the 4-bit counter at 0xF
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, LW, 5'd9, 5'd8, 5'd0, 32'h300);
      tick();
      drive(1'b1, ADD, 5'd8, 5'd1, 5'd2, 32'h304);
      tick();
      if (i == 12) check("sat_mid", 64'(bubble_cnt), 64'd14);
    end
    check("sat_cnt", 64'(bubble_cnt), 64'hF);
    // Async reset while a stall is being requested
    drive(1'b1, LW, 5'd9, 5'd8, 5'd0, 32'h400);
    tick();
    drive(1'b1, ADD, 5'd8, 5'd1, 5'd2, 32'h404);
    check("mr_hz_before", 64'(hazard_stall), 64'd1);
    reset = 1'b0;
    #1;
    check("mr_hz", 64'(hazard_stall), 64'd0);
    check("mr_valid", 64'(ex_valid), 64'd0);
    check("mr_ctrl", 64'(ex_ctrl), 64'd0);
    check("mr_cnt", 64'(bubble_cnt), 64'd0);
    check("mr_pc4", 64'(ex_pc4), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath. It captures the two register-bank read operands, the sign-extended immediate, the register specifiers and the decoded control bits each cycle, and presents them to the EX stage.
- It contains load-use hazard detection: it produces the stall request for PC and IF/ID and inserts a bubble into EX.
- It keeps a saturating count of inserted bubbles.

Parameters:
- addr_bits, 5, register specifier width
- word_wide, 32, datapath word width
- cnt_bits, 16, bubble counter width

Ports:
- clock  in  1  pipeline clock; all registers update on posedge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_readData1  in  word_wide  rs operand from register bank
- id_readData2  in  word_wide  rt operand from register bank
- id_imm  in  word_wide  sign-extended immediate
- id_pc4  in  word_wide  PC+4 of ID instruction
- id_rs, id_rt, id_rd  in  addr_bits each  register specifiers
- id_ctrl  in  9  {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[2:0]}
- flush  in  1  branch/jump taken: kill ID instruction
- ext_stall  in  1  downstream (memory) stall: freeze this stage
- ex_valid  out  1  EX holds a real instruction
- ex_readData1, ex_readData2, ex_imm, ex_pc4  out  word_wide  latched fields
- ex_rs, ex_rt, ex_rd  out  addr_bits  latched specifiers
- ex_ctrl  out  9  latched control
- hazard_stall  out  1  combinational stall request to PC and IF/ID
- bubble_cnt  out  cnt_bits  saturating count of inserted bubbles

Behaviour:
- Reset (reset==0, asynchronous): every registered output is 0, including ex_valid, ex_ctrl and bubble_cnt.
- hazard_stall = id_valid & ex_valid & ex_ctrl.memRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - Purely combinational, zero latency.
  - Forced to 0 while ext_stall=1 (EX is frozen, so the hazard stays pending).
- Per-posedge priority, highest first:
  - ext_stall=1: hold every ex_* register; bubble_cnt holds. This overrides flush; the upstream stage must keep flush asserted until it is accepted.
  - flush=1: load a bubble (ex_valid=0, ex_ctrl=0; data fields still load from ID, value irrelevant). bubble_cnt unchanged, because a flush is not a hazard bubble.
  - hazard_stall=1: load a bubble; bubble_cnt += 1.
  - otherwise: load all ID fields; ex_valid = id_valid; ex_ctrl = id_valid ? id_ctrl : 0.
- Bubble invariant: whenever ex_valid=0, ex_ctrl is 0, so no stray regWrite or memWrite ever reaches EX.
- Latency: one cycle from ID inputs to ex_* outputs.
- Load-use timing: exactly one bubble per load-use pair. In the next cycle the load has moved to MEM, so the comparison clears.
- bubble_cnt saturates at all-ones and does not wrap.
- Reset mid-stall: hazard_stall drops to 0 immediately, because ex_valid is cleared asynchronously.
- The register bank writes on negedge, so a same-cycle WB write is already visible on id_readData*. No WB bypass is needed by default.

Optional Feature:
- Macro: IDEX_WB_BYPASS_EN.
- When defined:
  - Extra inputs: wb_regWrite (1 bit), wb_writeReg (addr_bits), wb_writeData (word_wide).
  - If wb_regWrite & (wb_writeReg != 0) & (wb_writeReg == id_rs), load wb_writeData into ex_readData1 instead of id_readData1. The same rule applies to rt and ex_readData2.
  - Intended for register-bank builds that write on posedge.
- When undefined: the ports are absent and the operands are taken straight from the bank.

Decomposition:
- Shared package holds:
  - CTRL_W=9 and the bit indices CTRL_REGWRITE=8, CTRL_MEMREAD=7, CTRL_MEMWRITE=6, CTRL_MEMTOREG=5, CTRL_ALUSRC=4, CTRL_REGDST=3, CTRL_ALUOP=2:0
  - the ZERO_REG=0 constant
- One sub-module: idex_hazard_detect, the combinational load-use comparator producing hazard_stall.
- The pipeline registers and bubble_cnt stay in the top level.

Test Plan:
- Reset: drive reset=0 mid-run with ex_valid=1 → all ex_* outputs, bubble_cnt and hazard_stall read 0 immediately, with no clock edge needed.
- Plain pass-through: id_valid=1, id_readData1=0x11, id_readData2=0x22, id_imm=0xFFFFFFFC, id_ctrl=0x1A5 → after one posedge, ex_* show exactly those values and ex_valid=1.
- Load-use: EX holds lw with ex_rt=8 and memRead=1; ID holds add with id_rs=8 → hazard_stall=1 that cycle; the next edge gives ex_valid=0, ex_ctrl=0, bubble_cnt=1; the cycle after, hazard_stall=0 and the add enters EX.
- Register $0 and non-load:
  - lw with ex_rt=0 and id_rs=0 → hazard_stall=0.
  - A non-load in EX with ex_rt=id_rt=5 → hazard_stall=0.
- Priority:
  - flush and hazard together → bubble inserted, bubble_cnt unchanged.
  - ext_stall=1 with flush=1 → ex_* held and hazard_stall=0.
  - Release ext_stall with flush still high → bubble inserted.
- Saturation: with cnt_bits=4, force 17 consecutive load-use pairs → bubble_cnt stops at 0xF.
